// File: rtl/iwdg_pkg.sv
// rtl/iwdg_pkg.sv - shared constants and types for the IWDG Wishbone kicker
//
// Purpose: IWDG register map offsets, key values, status bit indices and
//          the kicker FSM state type.
// Ports:   none (package)
package iwdg_pkg;

    localparam int ADR_SIZE = 32;

    localparam logic [ADR_SIZE-1:0] OFS_KR  = 32'h0000_0000;
    localparam logic [ADR_SIZE-1:0] OFS_PR  = 32'h0000_0004;
    localparam logic [ADR_SIZE-1:0] OFS_RLR = 32'h0000_0008;
    localparam logic [ADR_SIZE-1:0] OFS_ST  = 32'h0000_000C;

    localparam logic [15:0] KEY_ACCESS = 16'h5555;
    localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
    localparam logic [15:0] KEY_COUNT  = 16'hCCCC;

    // ST register: prescaler / reload value update in progress
    localparam int ST_PVU = 0;
    localparam int ST_RVU = 1;

    typedef enum logic [3:0] {
        IDLE,
        UNLOCK,
        WR_RLR,
        WR_PR,
        POLL_ST,
        RELOAD,
        START_WD,
        WAIT,
        KICK,
        ERROR
    } kicker_state_e;

endpackage

// File: rtl/iwdg_wb_kicker_if.sv
// rtl/iwdg_wb_kicker_if.sv - Wishbone classic bus bundle between kicker and IWDG
//
// Purpose: groups the Wishbone initiator/target signals.
// Ports:   adr_m2s/dat_m2s/we_m2s/cyc_m2s/stb_m2s (initiator to target),
//          dat_s2m/ack_s2m (target to initiator).
//          Modports: master (kicker side), slave (IWDG side).
interface iwdg_wb_kicker_if #(
    parameter int DAT_SIZE = 16
);
    logic [31:0]         adr_m2s;
    logic [DAT_SIZE-1:0] dat_m2s;
    logic                we_m2s;
    logic                cyc_m2s;
    logic                stb_m2s;
    logic [DAT_SIZE-1:0] dat_s2m;
    logic                ack_s2m;

    modport master (
        output adr_m2s, dat_m2s, we_m2s, cyc_m2s, stb_m2s,
        input  dat_s2m, ack_s2m
    );

    modport slave (
        input  adr_m2s, dat_m2s, we_m2s, cyc_m2s, stb_m2s,
        output dat_s2m, ack_s2m
    );
endinterface

// File: rtl/wb_single_xfer.sv
// rtl/wb_single_xfer.sv - single Wishbone classic transaction engine with ack timeout
//
// Purpose: accepts one request while idle, runs the cyc/stb/ack handshake and
//          reports completion (done + rdata) or an ack timeout.
// Ports:   clk, rst (sync, active-low)
//          req/addr/wdata/we : request, sampled only while idle
//          done/rdata        : one-cycle completion pulse and captured read data
//          timeout           : one-cycle pulse when no ack within ACK_TIMEOUT cycles
//          adr_m2s..stb_m2s  : registered bus outputs, all zero while idle
//          dat_s2m/ack_s2m   : bus inputs
module wb_single_xfer
    import iwdg_pkg::*;
#(
    parameter int DAT_SIZE    = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [ADR_SIZE-1:0] addr,
    input  logic [DAT_SIZE-1:0] wdata,
    input  logic                we,
    output logic                done,
    output logic [DAT_SIZE-1:0] rdata,
    output logic                timeout,
    output logic [ADR_SIZE-1:0] adr_m2s,
    output logic [DAT_SIZE-1:0] dat_m2s,
    output logic                we_m2s,
    output logic                cyc_m2s,
    output logic                stb_m2s,
    input  logic [DAT_SIZE-1:0] dat_s2m,
    input  logic                ack_s2m
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    // Last cycle index (counted from 0 at issue) on which an ack is still accepted
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    logic                busy_q,    busy_d;
    logic [ADR_SIZE-1:0] adr_q,     adr_d;
    logic [DAT_SIZE-1:0] dat_q,     dat_d;
    logic                we_q,      we_d;
    logic [TO_W-1:0]     to_cnt_q,  to_cnt_d;
    logic [DAT_SIZE-1:0] rdata_q,   rdata_d;
    logic                done_q,    done_d;
    logic                timeout_q, timeout_d;

    always_comb begin
        busy_d    = busy_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        to_cnt_d  = to_cnt_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        if (!busy_q) begin
            if (req) begin
                busy_d   = 1'b1;
                adr_d    = addr;
                dat_d    = wdata;
                we_d     = we;
                to_cnt_d = '0;
            end
        end else if (ack_s2m) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rdata_d = dat_s2m;
            adr_d   = '0;
            dat_d   = '0;
            we_d    = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
            busy_d    = 1'b0;
            timeout_d = 1'b1;
            adr_d     = '0;
            dat_d     = '0;
            we_d      = 1'b0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q    <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            to_cnt_q  <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            to_cnt_q  <= to_cnt_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign cyc_m2s = busy_q;
    assign stb_m2s = busy_q;
    assign adr_m2s = adr_q;
    assign dat_m2s = dat_q;
    assign we_m2s  = we_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign rdata   = rdata_q;

endmodule

// File: rtl/iwdg_wb_kicker.sv
// rtl/iwdg_wb_kicker.sv - autonomous Wishbone initiator that configures, starts and refreshes the IWDG
//
// Purpose: runs unlock -> RLR -> PR -> (status poll) -> reload -> start, then
//          periodic KR=AAAA refreshes every kick_period cycles until stop.
// Ports:   clk, rst (sync, active-low)
//          start       : pulse, accepted in IDLE or ERROR; captures rlr_cfg/pr_cfg
//          stop        : level, holds off further kicks while in WAIT
//          rlr_cfg/pr_cfg/kick_period : configuration
//          wb          : Wishbone initiator (iwdg_wb_kicker_if.master)
//          running/err : watchdog started and kicked / sticky ack timeout
// Build option: IWDG_STATUS_POLL_EN adds the POLL_ST state that reads ST until
//          PVU/RVU are clear before reloading.
module iwdg_wb_kicker
    import iwdg_pkg::*;
#(
    parameter logic [31:0] BASE_ADR      = 32'h0100_0000,
    parameter int          DAT_SIZE      = 16,
    parameter int          KICK_CNT_SIZE = 16,
    parameter int          ACK_TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [11:0]              rlr_cfg,
    input  logic [2:0]               pr_cfg,
    input  logic [KICK_CNT_SIZE-1:0] kick_period,
    iwdg_wb_kicker_if.master         wb,
    output logic                     running,
    output logic                     err
);

    kicker_state_e            state_q, state_d, next_state;
    logic                     issued_q, issued_d;
    logic [KICK_CNT_SIZE-1:0] kick_cnt_q, kick_cnt_d;
    logic                     running_q, running_d;
    logic                     err_q, err_d;
    logic [11:0]              rlr_q, rlr_d;
    logic [2:0]               pr_q, pr_d;

    logic                     bus_state;
    logic                     xfer_req;
    logic [ADR_SIZE-1:0]      x_addr;
    logic [DAT_SIZE-1:0]      x_wdata;
    logic                     x_we;
    logic                     xfer_done;
    logic                     xfer_timeout;
    logic [DAT_SIZE-1:0]      xfer_rdata;
    logic [KICK_CNT_SIZE-1:0] kick_load;

    // A zero period would never reach the kick condition; run it as 1
    assign kick_load = (kick_period == '0) ? KICK_CNT_SIZE'(1) : kick_period;

`ifdef IWDG_STATUS_POLL_EN
    localparam logic [DAT_SIZE-1:0] ST_BUSY_MASK =
        DAT_SIZE'((1 << ST_PVU) | (1 << ST_RVU));
    logic st_ready;
    assign st_ready = (xfer_rdata & ST_BUSY_MASK) == '0;
`else
    // Read data only matters to the status poll
    logic unused_rdata;
    assign unused_rdata = ^xfer_rdata;
`endif

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        kick_cnt_d = kick_cnt_q;
        running_d  = running_q;
        err_d      = err_q;
        rlr_d      = rlr_q;
        pr_d       = pr_q;
        bus_state  = 1'b0;
        next_state = state_q;
        x_addr     = BASE_ADR + OFS_KR;
        x_wdata    = '0;
        x_we       = 1'b1;

        case (state_q)
            IDLE, ERROR: begin
                if (start) begin
                    state_d  = UNLOCK;
                    err_d    = 1'b0;
                    issued_d = 1'b0;
                    rlr_d    = rlr_cfg;
                    pr_d     = pr_cfg;
                end
            end
            UNLOCK: begin
                bus_state  = 1'b1;
                x_wdata    = DAT_SIZE'(KEY_ACCESS);
                next_state = WR_RLR;
            end
            WR_RLR: begin
                bus_state  = 1'b1;
                x_addr     = BASE_ADR + OFS_RLR;
                x_wdata    = DAT_SIZE'(rlr_q);
                next_state = WR_PR;
            end
            WR_PR: begin
                bus_state  = 1'b1;
                x_addr     = BASE_ADR + OFS_PR;
                x_wdata    = DAT_SIZE'(pr_q);
`ifdef IWDG_STATUS_POLL_EN
                next_state = POLL_ST;
`else
                next_state = RELOAD;
`endif
            end
`ifdef IWDG_STATUS_POLL_EN
            POLL_ST: begin
                bus_state  = 1'b1;
                x_addr     = BASE_ADR + OFS_ST;
                x_we       = 1'b0;
                next_state = st_ready ? RELOAD : POLL_ST;
            end
`endif
            RELOAD: begin
                bus_state  = 1'b1;
                x_wdata    = DAT_SIZE'(KEY_RELOAD);
                next_state = START_WD;
            end
            START_WD: begin
                bus_state  = 1'b1;
                x_wdata    = DAT_SIZE'(KEY_COUNT);
                next_state = WAIT;
            end
            WAIT: begin
                // Counter parks at 1 while stop is high so a kick follows
                // one cycle after stop is released
                if (kick_cnt_q <= KICK_CNT_SIZE'(1)) begin
                    kick_cnt_d = KICK_CNT_SIZE'(1);
                    if (!stop) begin
                        state_d = KICK;
                    end
                end else begin
                    kick_cnt_d = kick_cnt_q - 1'b1;
                end
            end
            KICK: begin
                bus_state  = 1'b1;
                x_wdata    = DAT_SIZE'(KEY_RELOAD);
                next_state = WAIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every bus state issues exactly one request, then waits for its
        // outcome; issued_q clears on completion so POLL_ST can re-issue
        if (bus_state) begin
            if (!issued_q) begin
                issued_d = 1'b1;
            end
            if (xfer_timeout) begin
                state_d   = ERROR;
                err_d     = 1'b1;
                running_d = 1'b0;
                issued_d  = 1'b0;
            end else if (xfer_done) begin
                state_d  = next_state;
                issued_d = 1'b0;
                if (state_q == START_WD || state_q == KICK) begin
                    kick_cnt_d = kick_load;
                end
                if (state_q == START_WD) begin
                    running_d = 1'b1;
                end
            end
        end
    end

    assign xfer_req = bus_state && !issued_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            issued_q   <= 1'b0;
            kick_cnt_q <= '0;
            running_q  <= 1'b0;
            err_q      <= 1'b0;
            rlr_q      <= '0;
            pr_q       <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            kick_cnt_q <= kick_cnt_d;
            running_q  <= running_d;
            err_q      <= err_d;
            rlr_q      <= rlr_d;
            pr_q       <= pr_d;
        end
    end

    assign running = running_q;
    assign err     = err_q;

    wb_single_xfer #(
        .DAT_SIZE    (DAT_SIZE),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .req     (xfer_req),
        .addr    (x_addr),
        .wdata   (x_wdata),
        .we      (x_we),
        .done    (xfer_done),
        .rdata   (xfer_rdata),
        .timeout (xfer_timeout),
        .adr_m2s (wb.adr_m2s),
        .dat_m2s (wb.dat_m2s),
        .we_m2s  (wb.we_m2s),
        .cyc_m2s (wb.cyc_m2s),
        .stb_m2s (wb.stb_m2s),
        .dat_s2m (wb.dat_s2m),
        .ack_s2m (wb.ack_s2m)
    );

endmodule

// File: doc/iwdg_wb_kicker.md
Name: iwdg_wb_kicker

Overview:
- Autonomous Wishbone classic initiator that configures, starts and periodically refreshes the IWDG over its register interface; it drives the same master-side signals the IWDG slave port expects.
- Sits between system control logic and the IWDG slave port.
- Replaces software kicking: control logic supplies reload/prescale values and a kick period, and the block runs the unlock → configure → reload → start → periodic-refresh sequence.

Parameters:
- BASE_ADR, 32'h0100_0000, IWDG base address; KR/PR/RLR/ST sit at offsets +0/+4/+8/+C.
- DAT_SIZE, 16, Wishbone data width.
- KICK_CNT_SIZE, 16, width of the kick-interval counter.
- ACK_TIMEOUT, 15, maximum cycles to wait for ack_s2m before erroring.

Ports:
- clk  in  1  bus clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begins the sequence from IDLE or ERROR
- stop  in  1  level; while high, no further kicks are issued (watchdog will bite)
- rlr_cfg  in  12  reload value written to RLR
- pr_cfg  in  3  prescaler code written to PR
- kick_period  in  KICK_CNT_SIZE  clk cycles between refreshes; 0 is treated as 1
- adr_m2s  out  32  Wishbone address
- dat_m2s  out  DAT_SIZE  Wishbone write data
- we_m2s  out  1  write enable
- cyc_m2s  out  1  bus cycle
- stb_m2s  out  1  strobe
- dat_s2m  in  DAT_SIZE  read data
- ack_s2m  in  1  slave acknowledge
- running  out  1  watchdog started and being kicked
- err  out  1  ack timeout occurred; sticky until start

Behaviour:
- Reset (rst==0 at posedge clk):
  - all outputs 0, FSM→IDLE, counters cleared.
  - Reset mid-transaction drops cyc/stb on the next edge with no completion.
- Transaction rules:
  - Issue: drive adr/dat/we, then assert cyc_m2s=stb_m2s=1 in the same cycle. All four stay stable until ack_s2m is sampled high.
  - Completion: on the ack edge, deassert cyc/stb on the following cycle. Read data is captured on that edge.
  - Spacing: at least one idle cycle (cyc=0) between transactions.
  - Timeout: a per-transaction counter resets at issue. If it reaches ACK_TIMEOUT without ack, drop cyc/stb, set err=1, clear running, go to ERROR.
- FSM states: IDLE, UNLOCK, WR_RLR, WR_PR, POLL_ST, RELOAD, START_WD, WAIT, KICK, ERROR.
  - IDLE: on start → UNLOCK.
  - UNLOCK: write KR=16'h5555 → WR_RLR.
  - WR_RLR: write RLR={4'b0,rlr_cfg} → WR_PR.
  - WR_PR: write PR={13'b0,pr_cfg} → POLL_ST (feature on) or RELOAD (feature off).
  - RELOAD: write KR=16'hAAAA → START_WD.
  - START_WD: write KR=16'hCCCC. On ack, running=1 and the kick counter is loaded with kick_period → WAIT.
  - WAIT: counter decrements each cycle. At 1, if stop==0 → KICK; if stop==1, stay in WAIT with the counter held at 1.
  - KICK: write KR=16'hAAAA. On ack, reload the counter → WAIT.
  - ERROR: outputs idle; start → UNLOCK with err cleared.
- Config capture: rlr_cfg/pr_cfg are sampled at start; later changes are ignored until the next start.
- Priority when events coincide:
  - start while not in IDLE/ERROR is ignored.
  - stop is sampled only in WAIT.
  - An in-flight transaction always completes or times out.
- kick_period==0 behaves as 1, i.e. one idle cycle between kicks.

Optional Feature:
- IWDG_STATUS_POLL_EN:
  - Defined: POLL_ST reads ST repeatedly until dat_s2m[1:0]==2'b00 (PVU/RVU clear), then → RELOAD. Each read has its own ack timeout; there is no overall poll limit.
  - Undefined: POLL_ST does not exist and WR_PR → RELOAD directly.

Decomposition:
- Package iwdg_pkg:
  - register offsets and address sizes;
  - key constants KEY_ACCESS=16'h5555, KEY_RELOAD=16'hAAAA, KEY_COUNT=16'hCCCC;
  - ST bit indices;
  - state enum typedef.
- Sub-module wb_single_xfer: one-transaction engine covering req/addr/data/we in, done/rdata/timeout out, and the cyc/stb/ack handshake with timeout. The kicker FSM sequences it.

Test Plan:
- Reset, then start with rlr_cfg=12'h001, pr_cfg=3'b001, kick_period=20, slave acking in 1 cycle → bus writes in order: KR 5555, RLR 001, PR 001, KR AAAA, KR CCCC. running=1 after the CCCC ack.
- Steady state, kick_period=20 → KR AAAA writes every 20 + transaction-latency cycles. The IWDG model's iwdg_rst is never asserted over 500 cycles.
- Assert stop after the second kick → no further bus activity, running stays 1, and the IWDG model asserts iwdg_rst after its countdown expires.
- Slave withholds ack on the RLR write → after 15 cycles cyc/stb drop, err=1, running=0. A following start restarts from the 5555 write with err=0.
- With IWDG_STATUS_POLL_EN, slave returns ST=2'b01 three times, then 2'b00 → exactly four ST reads, then the AAAA write. Without the macro, no ST read occurs.
- Pull rst low during the CCCC transaction → cyc/stb=0 next edge, all outputs 0, FSM in IDLE, and no kicks until start.
